// File: rtl/ctrlport_resp_timeout.sv
// CTRL Port watchdog: forwards requests, returns CMDERR when no ack arrives.
// Define CTRLPORT_TIMEOUT_COUNT_EN to add the 16-bit timeout_count output.
module ctrlport_resp_timeout #(
    parameter int TIMEOUT             = 1024,
    parameter int TIMED_NO_TIMEOUT    = 1,
    parameter int CTRLPORT_ADDR_W     = 20,
    parameter int CTRLPORT_DATA_W     = 32,
    parameter int CTRLPORT_PORTID_W   = 10,
    parameter int CTRLPORT_REM_EPID_W = 16,
    parameter int CTRLPORT_BYTE_EN_W  = 4,
    parameter int CTRLPORT_TIME_W     = 64,
    parameter int CTRLPORT_STS_W      = 2
) (
    input  logic                           ctrlport_clk,
    input  logic                           ctrlport_rst_n,
    input  logic                           s_ctrlport_req_wr,
    input  logic                           s_ctrlport_req_rd,
    input  logic [CTRLPORT_ADDR_W-1:0]     s_ctrlport_req_addr,
    input  logic [CTRLPORT_PORTID_W-1:0]   s_ctrlport_req_portid,
    input  logic [CTRLPORT_REM_EPID_W-1:0] s_ctrlport_req_rem_epid,
    input  logic [CTRLPORT_PORTID_W-1:0]   s_ctrlport_req_rem_portid,
    input  logic [CTRLPORT_DATA_W-1:0]     s_ctrlport_req_data,
    input  logic [CTRLPORT_BYTE_EN_W-1:0]  s_ctrlport_req_byte_en,
    input  logic                           s_ctrlport_req_has_time,
    input  logic [CTRLPORT_TIME_W-1:0]     s_ctrlport_req_time,
    output logic                           s_ctrlport_resp_ack,
    output logic [CTRLPORT_STS_W-1:0]      s_ctrlport_resp_status,
    output logic [CTRLPORT_DATA_W-1:0]     s_ctrlport_resp_data,
    output logic                           m_ctrlport_req_wr,
    output logic                           m_ctrlport_req_rd,
    output logic [CTRLPORT_ADDR_W-1:0]     m_ctrlport_req_addr,
    output logic [CTRLPORT_PORTID_W-1:0]   m_ctrlport_req_portid,
    output logic [CTRLPORT_REM_EPID_W-1:0] m_ctrlport_req_rem_epid,
    output logic [CTRLPORT_PORTID_W-1:0]   m_ctrlport_req_rem_portid,
    output logic [CTRLPORT_DATA_W-1:0]     m_ctrlport_req_data,
    output logic [CTRLPORT_BYTE_EN_W-1:0]  m_ctrlport_req_byte_en,
    output logic                           m_ctrlport_req_has_time,
    output logic [CTRLPORT_TIME_W-1:0]     m_ctrlport_req_time,
    input  logic                           m_ctrlport_resp_ack,
    input  logic [CTRLPORT_STS_W-1:0]      m_ctrlport_resp_status,
    input  logic [CTRLPORT_DATA_W-1:0]     m_ctrlport_resp_data
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
    ,
    output logic [15:0]                    timeout_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CTRLPORT_STS_W-1:0] STS_CMDERR = CTRLPORT_STS_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ORPHAN} state_t;

    typedef struct packed {
        logic [CTRLPORT_ADDR_W-1:0]     addr;
        logic [CTRLPORT_PORTID_W-1:0]   portid;
        logic [CTRLPORT_REM_EPID_W-1:0] rem_epid;
        logic [CTRLPORT_PORTID_W-1:0]   rem_portid;
        logic [CTRLPORT_DATA_W-1:0]     data;
        logic [CTRLPORT_BYTE_EN_W-1:0]  byte_en;
        logic                           has_time;
        logic [CTRLPORT_TIME_W-1:0]     time_v;
    } req_t;

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        m_wr_q;
    logic                        m_rd_q;
    req_t                        req_q;
    logic                        s_ack_q;
    logic [CTRLPORT_STS_W-1:0]   s_sts_q;
    logic [CTRLPORT_DATA_W-1:0]  s_data_q;

    logic req_in;
    logic cnt_last;
    logic no_timeout;
    logic timeout_evt;
    logic reject_evt;

    assign req_in      = s_ctrlport_req_wr | s_ctrlport_req_rd;
    assign cnt_last    = (cnt_q == CNT_LAST);
    assign no_timeout  = (TIMED_NO_TIMEOUT != 0) && req_q.has_time;
    // A real ack always wins over an expiring counter.
    assign timeout_evt = (state_q == ST_WAIT) && !m_ctrlport_resp_ack
                         && !no_timeout && cnt_last;
    assign reject_evt  = (state_q == ST_ORPHAN) && req_in;

    // Watchdog FSM with registered request and response outputs.
    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            m_wr_q   <= 1'b0;
            m_rd_q   <= 1'b0;
            req_q    <= '0;
            s_ack_q  <= 1'b0;
            s_sts_q  <= '0;
            s_data_q <= '0;
        end else begin
            m_wr_q   <= 1'b0;
            m_rd_q   <= 1'b0;
            s_ack_q  <= 1'b0;
            s_sts_q  <= '0;
            s_data_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_in) begin
                        m_wr_q  <= s_ctrlport_req_wr;
                        m_rd_q  <= s_ctrlport_req_rd;
                        req_q   <= '{s_ctrlport_req_addr,
                                     s_ctrlport_req_portid,
                                     s_ctrlport_req_rem_epid,
                                     s_ctrlport_req_rem_portid,
                                     s_ctrlport_req_data,
                                     s_ctrlport_req_byte_en,
                                     s_ctrlport_req_has_time,
                                     s_ctrlport_req_time};
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_ctrlport_resp_ack) begin
                        s_ack_q  <= 1'b1;
                        s_sts_q  <= m_ctrlport_resp_status;
                        s_data_q <= m_ctrlport_resp_data;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else if (no_timeout) begin
                        cnt_q <= '0;
                    end else if (timeout_evt) begin
                        s_ack_q <= 1'b1;
                        s_sts_q <= STS_CMDERR;
                        cnt_q   <= '0;
                        state_q <= ST_ORPHAN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ORPHAN: begin
                    if (reject_evt) begin
                        s_ack_q <= 1'b1;
                        s_sts_q <= STS_CMDERR;
                    end
                    if (m_ctrlport_resp_ack || cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CTRLPORT_TIMEOUT_COUNT_EN
    logic [15:0] tc_q;

    // Saturating count of timeouts plus orphan-state rejections.
    always_ff @(posedge ctrlport_clk) begin
        if (!ctrlport_rst_n) begin
            tc_q <= '0;
        end else if ((timeout_evt || reject_evt) && (tc_q != 16'hFFFF)) begin
            tc_q <= tc_q + 16'd1;
        end
    end

    assign timeout_count = tc_q;
`endif

    assign s_ctrlport_resp_ack       = s_ack_q;
    assign s_ctrlport_resp_status    = s_sts_q;
    assign s_ctrlport_resp_data      = s_data_q;
    assign m_ctrlport_req_wr         = m_wr_q;
    assign m_ctrlport_req_rd         = m_rd_q;
    assign m_ctrlport_req_addr       = req_q.addr;
    assign m_ctrlport_req_portid     = req_q.portid;
    assign m_ctrlport_req_rem_epid   = req_q.rem_epid;
    assign m_ctrlport_req_rem_portid = req_q.rem_portid;
    assign m_ctrlport_req_data       = req_q.data;
    assign m_ctrlport_req_byte_en    = req_q.byte_en;
    assign m_ctrlport_req_has_time   = req_q.has_time;
    assign m_ctrlport_req_time       = req_q.time_v;

endmodule

// File: tb/tb_ctrlport_resp_timeout.sv
// Bench for ctrlport_resp_timeout: directed scenarios plus random traffic
// checked against a deadline-based transaction model.
module tb_ctrlport_resp_timeout;

    localparam int TO = 16;

    logic        ctrlport_clk = 1'b0;
    logic        ctrlport_rst_n;
    logic        s_ctrlport_req_wr;
    logic        s_ctrlport_req_rd;
    logic [19:0] s_ctrlport_req_addr;
    logic [9:0]  s_ctrlport_req_portid;
    logic [15:0] s_ctrlport_req_rem_epid;
    logic [9:0]  s_ctrlport_req_rem_portid;
    logic [31:0] s_ctrlport_req_data;
    logic [3:0]  s_ctrlport_req_byte_en;
    logic        s_ctrlport_req_has_time;
    logic [63:0] s_ctrlport_req_time;
    logic        s_ctrlport_resp_ack;
    logic [1:0]  s_ctrlport_resp_status;
    logic [31:0] s_ctrlport_resp_data;
    logic        m_ctrlport_req_wr;
    logic        m_ctrlport_req_rd;
    logic [19:0] m_ctrlport_req_addr;
    logic [9:0]  m_ctrlport_req_portid;
    logic [15:0] m_ctrlport_req_rem_epid;
    logic [9:0]  m_ctrlport_req_rem_portid;
    logic [31:0] m_ctrlport_req_data;
    logic [3:0]  m_ctrlport_req_byte_en;
    logic        m_ctrlport_req_has_time;
    logic [63:0] m_ctrlport_req_time;
    logic        m_ctrlport_resp_ack;
    logic [1:0]  m_ctrlport_resp_status;
    logic [31:0] m_ctrlport_resp_data;
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
    logic [15:0] timeout_count;
`endif

    always #5 ctrlport_clk = ~ctrlport_clk;

    ctrlport_resp_timeout #(
        .TIMEOUT(TO),
        .TIMED_NO_TIMEOUT(1)
    ) dut (
        .ctrlport_clk(ctrlport_clk),
        .ctrlport_rst_n(ctrlport_rst_n),
        .s_ctrlport_req_wr(s_ctrlport_req_wr),
        .s_ctrlport_req_rd(s_ctrlport_req_rd),
        .s_ctrlport_req_addr(s_ctrlport_req_addr),
        .s_ctrlport_req_portid(s_ctrlport_req_portid),
        .s_ctrlport_req_rem_epid(s_ctrlport_req_rem_epid),
        .s_ctrlport_req_rem_portid(s_ctrlport_req_rem_portid),
        .s_ctrlport_req_data(s_ctrlport_req_data),
        .s_ctrlport_req_byte_en(s_ctrlport_req_byte_en),
        .s_ctrlport_req_has_time(s_ctrlport_req_has_time),
        .s_ctrlport_req_time(s_ctrlport_req_time),
        .s_ctrlport_resp_ack(s_ctrlport_resp_ack),
        .s_ctrlport_resp_status(s_ctrlport_resp_status),
        .s_ctrlport_resp_data(s_ctrlport_resp_data),
        .m_ctrlport_req_wr(m_ctrlport_req_wr),
        .m_ctrlport_req_rd(m_ctrlport_req_rd),
        .m_ctrlport_req_addr(m_ctrlport_req_addr),
        .m_ctrlport_req_portid(m_ctrlport_req_portid),
        .m_ctrlport_req_rem_epid(m_ctrlport_req_rem_epid),
        .m_ctrlport_req_rem_portid(m_ctrlport_req_rem_portid),
        .m_ctrlport_req_data(m_ctrlport_req_data),
        .m_ctrlport_req_byte_en(m_ctrlport_req_byte_en),
        .m_ctrlport_req_has_time(m_ctrlport_req_has_time),
        .m_ctrlport_req_time(m_ctrlport_req_time),
        .m_ctrlport_resp_ack(m_ctrlport_resp_ack),
        .m_ctrlport_resp_status(m_ctrlport_resp_status),
        .m_ctrlport_resp_data(m_ctrlport_resp_data)
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
        ,
        .timeout_count(timeout_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: transaction mode plus absolute deadline cycle.
    longint cyc = 0;
    longint dl = 0;
    int     md_mode = 0;   // 0 idle, 1 outstanding, 2 error already returned
    bit     md_timed = 1'b0;
    logic         e_ack, e_wr, e_rd;
    logic [1:0]   e_sts;
    logic [31:0]  e_data;
    logic [156:0] e_flds;
    int           e_tc = 0;

    function automatic logic [36:0] sresp();
        return {s_ctrlport_resp_ack, s_ctrlport_resp_status,
                s_ctrlport_resp_data, m_ctrlport_req_wr, m_ctrlport_req_rd};
    endfunction

    function automatic logic [156:0] mflds();
        return {m_ctrlport_req_addr, m_ctrlport_req_portid,
                m_ctrlport_req_rem_epid, m_ctrlport_req_rem_portid,
                m_ctrlport_req_data, m_ctrlport_req_byte_en,
                m_ctrlport_req_has_time, m_ctrlport_req_time};
    endfunction

    function automatic logic [36:0] eresp();
        return {e_ack, e_sts, e_data, e_wr, e_rd};
    endfunction

    task automatic model_clear();
        md_mode = 0; md_timed = 1'b0;
        e_ack = 0; e_wr = 0; e_rd = 0; e_sts = 0; e_data = 0;
        e_flds = '0; e_tc = 0;
    endtask

    // Present one cycle of inputs, advance the model, step the clock.
    task automatic drive(input bit wr, input bit rd, input bit ht,
                         input bit ack, input logic [1:0] asts,
                         input logic [31:0] adata,
                         input logic [19:0] addr, input logic [31:0] wdata);
        s_ctrlport_req_wr         = wr;
        s_ctrlport_req_rd         = rd;
        s_ctrlport_req_addr       = addr;
        s_ctrlport_req_portid     = 10'($urandom);
        s_ctrlport_req_rem_epid   = 16'($urandom);
        s_ctrlport_req_rem_portid = 10'($urandom);
        s_ctrlport_req_data       = wdata;
        s_ctrlport_req_byte_en    = 4'($urandom);
        s_ctrlport_req_has_time   = ht;
        s_ctrlport_req_time       = {$urandom, $urandom};
        m_ctrlport_resp_ack       = ack;
        m_ctrlport_resp_status    = ack ? asts : 2'($urandom);
        m_ctrlport_resp_data      = ack ? adata : $urandom;
        e_ack = 0; e_wr = 0; e_rd = 0; e_sts = 0; e_data = 0;
        case (md_mode)
            0: if (wr || rd) begin
                e_wr = wr; e_rd = rd;
                e_flds = {addr, s_ctrlport_req_portid,
                          s_ctrlport_req_rem_epid, s_ctrlport_req_rem_portid,
                          wdata, s_ctrlport_req_byte_en, ht,
                          s_ctrlport_req_time};
                md_mode = 1; md_timed = ht; dl = cyc + TO;
            end
            1: if (ack) begin
                e_ack = 1; e_sts = asts; e_data = adata; md_mode = 0;
            end else if (!md_timed && cyc == dl) begin
                e_ack = 1; e_sts = 2'd1; md_mode = 2; dl = cyc + TO;
                if (e_tc < 65535) e_tc++;
            end
            default: begin
                if (wr || rd) begin
                    e_ack = 1; e_sts = 2'd1;
                    if (e_tc < 65535) e_tc++;
                end
                if (ack || cyc == dl) md_mode = 0;
            end
        endcase
        @(posedge ctrlport_clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 2'd0, 32'd0, 20'($urandom), $urandom);
    endtask

    task automatic ack_cycle(input logic [1:0] sts, input logic [31:0] d);
        drive(0, 0, 0, 1, sts, d, 20'($urandom), $urandom);
    endtask

    task automatic do_reset();
        ctrlport_rst_n = 1'b0;
        s_ctrlport_req_wr = 1'b1;
        s_ctrlport_req_rd = 1'b0;
        m_ctrlport_resp_ack = 1'b1;
        m_ctrlport_resp_status = 2'd3;
        m_ctrlport_resp_data = $urandom;
        @(posedge ctrlport_clk);
        cyc++;
        #1;
        ctrlport_rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sresp(), mflds()} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {sresp(), mflds()});
        end
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
        checks++;
        if (timeout_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_tc got=%0d want=0", timeout_count);
        end
`endif
    endtask

    task automatic test_write_ack();
        drive(1, 0, 0, 0, 2'd0, 32'd0, 20'h40, 32'hDEADBEEF);
        checks++;
        if ({m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr,
             m_ctrlport_req_data} !== {1'b1, 1'b0, 20'h40, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL wr_fwd got=%b%b %h %h want=10 00040 deadbeef",
                     m_ctrlport_req_wr, m_ctrlport_req_rd,
                     m_ctrlport_req_addr, m_ctrlport_req_data);
        end
        checks++;
        if (mflds() !== e_flds) begin
            failures++;
            $display("FAIL wr_fields got=%h want=%h", mflds(), e_flds);
        end
        for (int k = 1; k < 5; k++) begin
            idle();
            checks++;
            if ({s_ctrlport_resp_ack, m_ctrlport_req_wr} !== 2'b00) begin
                failures++;
                $display("FAIL wr_wait%0d got ack=%b wr=%b want 0 0",
                         k, s_ctrlport_resp_ack, m_ctrlport_req_wr);
            end
        end
        ack_cycle(2'd0, 32'h1234);
        checks++;
        if ({s_ctrlport_resp_ack, s_ctrlport_resp_status,
             s_ctrlport_resp_data} !== {1'b1, 2'd0, 32'h1234}) begin
            failures++;
            $display("FAIL wr_ack got=%b %0d %h want=1 0 00001234",
                     s_ctrlport_resp_ack, s_ctrlport_resp_status,
                     s_ctrlport_resp_data);
        end
        idle();
        checks++;
        if (sresp() !== '0) begin
            failures++;
            $display("FAIL wr_ack_pulse got=%h want=0", sresp());
        end
    endtask

    task automatic test_timeout_orphan();
        int tc0;
        tc0 = e_tc;
        for (int k = 0; k <= TO; k++) begin
            drive(0, k == 0, 0, 0, 2'd0, 32'd0, 20'h80, $urandom);
            if (k < TO) begin
                if (s_ctrlport_resp_ack !== 1'b0) begin
                    checks++; failures++;
                    $display("FAIL to_early cycle=%0d got ack=1 want 0", k + 1);
                end
            end else begin
                checks++;
                if ({s_ctrlport_resp_ack, s_ctrlport_resp_status,
                     s_ctrlport_resp_data} !== {1'b1, 2'd1, 32'd0}) begin
                    failures++;
                    $display("FAIL to_err got=%b %0d %h want=1 1 0",
                             s_ctrlport_resp_ack, s_ctrlport_resp_status,
                             s_ctrlport_resp_data);
                end
            end
        end
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
        checks++;
        if (timeout_count !== 16'(tc0 + 1)) begin
            failures++;
            $display("FAIL to_count got=%0d want=%0d", timeout_count, tc0 + 1);
        end
`endif
        idle();
        drive(1, 0, 0, 0, 2'd0, 32'd0, 20'h44, $urandom);
        checks++;
        if ({s_ctrlport_resp_ack, s_ctrlport_resp_status, s_ctrlport_resp_data,
             m_ctrlport_req_wr} !== {1'b1, 2'd1, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL orphan_reject got=%h want=%h",
                     {s_ctrlport_resp_ack, s_ctrlport_resp_status,
                      s_ctrlport_resp_data, m_ctrlport_req_wr},
                     {1'b1, 2'd1, 32'd0, 1'b0});
        end
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
        checks++;
        if (timeout_count !== 16'(tc0 + 2)) begin
            failures++;
            $display("FAIL reject_count got=%0d want=%0d",
                     timeout_count, tc0 + 2);
        end
`endif
        idle();
        ack_cycle(2'd0, 32'hABCD);
        checks++;
        if (s_ctrlport_resp_ack !== 1'b0) begin
            failures++;
            $display("FAIL late_ack_swallow got ack=1 want 0");
        end
        drive(0, 1, 0, 0, 2'd0, 32'd0, 20'h88, $urandom);
        checks++;
        if ({m_ctrlport_req_rd, m_ctrlport_req_addr} !== {1'b1, 20'h88}) begin
            failures++;
            $display("FAIL after_orphan_fwd got=%b %h want=1 00088",
                     m_ctrlport_req_rd, m_ctrlport_req_addr);
        end
        ack_cycle(2'd2, 32'h77);
        checks++;
        if (sresp() !== {1'b1, 2'd2, 32'h77, 2'b00}) begin
            failures++;
            $display("FAIL after_orphan_ack got=%h want=%h",
                     sresp(), {1'b1, 2'd2, 32'h77, 2'b00});
        end
    endtask

    task automatic test_timed();
        int bad;
        bad = 0;
        drive(0, 1, 1, 0, 2'd0, 32'd0, 20'h100, $urandom);
        for (int k = 1; k < 100; k++) begin
            idle();
            if (s_ctrlport_resp_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timed_no_err got=%0d acks want=0", bad);
        end
        ack_cycle(2'd0, 32'hCAFE0001);
        checks++;
        if (sresp() !== {1'b1, 2'd0, 32'hCAFE0001, 2'b00}) begin
            failures++;
            $display("FAIL timed_ack got=%h want=%h",
                     sresp(), {1'b1, 2'd0, 32'hCAFE0001, 2'b00});
        end
    endtask

    task automatic test_simultaneous();
        drive(0, 1, 0, 0, 2'd0, 32'd0, 20'h200, $urandom);
        for (int k = 1; k < TO; k++) idle();
        ack_cycle(2'd2, 32'h55AA);
        checks++;
        if (sresp() !== {1'b1, 2'd2, 32'h55AA, 2'b00}) begin
            failures++;
            $display("FAIL edge_ack got=%h want=%h",
                     sresp(), {1'b1, 2'd2, 32'h55AA, 2'b00});
        end
        drive(0, 1, 0, 0, 2'd0, 32'd0, 20'h204, $urandom);
        for (int k = 1; k <= TO; k++) idle();
        idle();
        drive(0, 1, 0, 1, 2'd0, 32'h9, 20'h208, $urandom);
        checks++;
        if (sresp() !== {1'b1, 2'd1, 32'd0, 2'b00}) begin
            failures++;
            $display("FAIL orphan_ack_req got=%h want=%h",
                     sresp(), {1'b1, 2'd1, 32'd0, 2'b00});
        end
        drive(0, 1, 0, 0, 2'd0, 32'd0, 20'h20C, $urandom);
        checks++;
        if ({m_ctrlport_req_rd, m_ctrlport_req_addr} !== {1'b1, 20'h20C}) begin
            failures++;
            $display("FAIL orphan_then_idle got=%b %h want=1 0020c",
                     m_ctrlport_req_rd, m_ctrlport_req_addr);
        end
        ack_cycle(2'd0, 32'd5);
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 0, 2'd0, 32'd0, 20'h300, $urandom);
        idle();
        drive(1, 0, 0, 0, 2'd0, 32'd0, 20'h3FF, $urandom);
        checks++;
        if ({m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr,
             s_ctrlport_resp_ack} !== {2'b00, 20'h300, 1'b0}) begin
            failures++;
            $display("FAIL drop_in_wait got=%b%b %h ack=%b want=00 00300 0",
                     m_ctrlport_req_wr, m_ctrlport_req_rd,
                     m_ctrlport_req_addr, s_ctrlport_resp_ack);
        end
        ack_cycle(2'd3, 32'h3);
        checks++;
        if (sresp() !== {1'b1, 2'd3, 32'h3, 2'b00}) begin
            failures++;
            $display("FAIL drop_then_ack got=%h want=%h",
                     sresp(), {1'b1, 2'd3, 32'h3, 2'b00});
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 0, 2'd0, 32'd0, 20'h400, $urandom);
        idle();
        idle();
        do_reset();
        checks++;
        if ({sresp(), mflds()} !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h want=0", {sresp(), mflds()});
        end
        drive(1, 0, 0, 0, 2'd0, 32'd0, 20'h404, 32'h11);
        checks++;
        if ({m_ctrlport_req_wr, m_ctrlport_req_addr} !== {1'b1, 20'h404}) begin
            failures++;
            $display("FAIL post_reset_fwd got=%b %h want=1 00404",
                     m_ctrlport_req_wr, m_ctrlport_req_addr);
        end
        ack_cycle(2'd0, 32'h22);
        checks++;
        if (sresp() !== {1'b1, 2'd0, 32'h22, 2'b00}) begin
            failures++;
            $display("FAIL post_reset_ack got=%h want=%h",
                     sresp(), {1'b1, 2'd0, 32'h22, 2'b00});
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 3000; n++) begin
            bit r, w, ht, ak;
            r  = ($urandom_range(0, 3) == 0);
            w  = r && $urandom_range(0, 1);
            ak = ($urandom_range(0, 19) == 0);
            ht = ($urandom_range(0, 3) == 0);
            drive(w, r && !w, ht, ak, 2'($urandom), $urandom,
                  20'($urandom), $urandom);
            checks++;
            if (sresp() !== eresp() || mflds() !== e_flds) begin
                failures++;
                if (errs < 10)
                    $display("FAIL rand_cycle%0d got=%h/%h want=%h/%h",
                             n, sresp(), mflds(), eresp(), e_flds);
                errs++;
            end
`ifdef CTRLPORT_TIMEOUT_COUNT_EN
            checks++;
            if (timeout_count !== 16'(e_tc)) begin
                failures++;
                if (errs < 10)
                    $display("FAIL rand_tc got=%0d want=%0d",
                             timeout_count, e_tc);
                errs++;
            end
`endif
        end
    endtask

    initial begin
        ctrlport_rst_n = 1'b0;
        s_ctrlport_req_wr = 0; s_ctrlport_req_rd = 0;
        s_ctrlport_req_addr = 0; s_ctrlport_req_portid = 0;
        s_ctrlport_req_rem_epid = 0; s_ctrlport_req_rem_portid = 0;
        s_ctrlport_req_data = 0; s_ctrlport_req_byte_en = 0;
        s_ctrlport_req_has_time = 0; s_ctrlport_req_time = 0;
        m_ctrlport_resp_ack = 0; m_ctrlport_resp_status = 0;
        m_ctrlport_resp_data = 0;
        model_clear();
        @(posedge ctrlport_clk);
        #1;
        test_reset();
        test_write_ack();
        test_timeout_orphan();
        test_timed();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
